// File: rtl/jtag_user_reg_bank.sv
// Addressed bank of JTAG user registers behind a BSCAN user chain (TCK domain).
// A fixed-length DR frame either writes one output channel or selects an input channel for readback.

module jtag_user_reg_chan #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic             TCK,
  input  logic             RESET,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q,
  output logic             strobe
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             stb_q, stb_d;

  always_comb begin
    q_d   = we ? wdata : q_q;
    stb_d = we;
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      q_q   <= INIT_VAL;
      stb_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      stb_q <= stb_d;
    end
  end

  assign q      = q_q;
  assign strobe = stb_q;
endmodule

module jtag_user_reg_bank #(
  parameter int               NUM_REGS = 4,
  parameter int               WIDTH    = 32,
  parameter int               ADDR_W   = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                      TCK,
  input  logic                      RESET,
  input  logic                      iTDI,
  input  logic                      capture,
  input  logic                      shift,
  input  logic                      update,
  output logic                      oTDO,
  output logic [NUM_REGS*WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]       wr_strobe,
  input  logic [NUM_REGS*WIDTH-1:0] reg_in
);
  localparam int FRAME_LEN = WIDTH + ADDR_W + 2;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);

  typedef enum logic [1:0] {IDLE, SHIFTING, UPDATE} state_t;

  state_t                    state_q, state_d;
  logic [FRAME_LEN-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic                      addr_err_q, addr_err_d;
  logic                      frame_err_q, frame_err_d;
  logic [NUM_REGS*WIDTH-1:0] in_q, in_d;

  logic [WIDTH-1:0]  frm_data, rd_data;
  logic [ADDR_W-1:0] frm_addr;
  logic              frm_wr, frm_rd, addr_ok, frame_ok, upd_act;
  logic [NUM_REGS-1:0] we;

  assign frm_data = sr_q[WIDTH-1:0];
  assign frm_addr = sr_q[WIDTH +: ADDR_W];
  assign frm_wr   = sr_q[FRAME_LEN-2];
  assign frm_rd   = sr_q[FRAME_LEN-1];
  assign addr_ok  = {1'b0, frm_addr} < (ADDR_W+1)'(NUM_REGS);
  assign frame_ok = cnt_q == CNT_W'(FRAME_LEN);
  // Update only counts when it closes a frame opened by capture; capture outranks it.
  assign upd_act  = update && !capture && (state_q == SHIFTING);

  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NUM_REGS; n++)
      if (rd_ptr_q == ADDR_W'(n)) rd_data = in_q[n*WIDTH +: WIDTH];
  end

  always_comb begin
    we = '0;
    for (int n = 0; n < NUM_REGS; n++)
      we[n] = upd_act && frame_ok && addr_ok && frm_wr && (frm_addr == ADDR_W'(n));
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    addr_err_d  = addr_err_q;
    frame_err_d = frame_err_q;
    in_d        = reg_in;
    if (state_q == UPDATE) state_d = IDLE;
    if (capture) begin
      // Status is read-to-clear: flags are reported in this frame and dropped.
      sr_d        = {frame_err_q, addr_err_q, rd_ptr_q, rd_data};
      cnt_d       = '0;
      addr_err_d  = 1'b0;
      frame_err_d = 1'b0;
      state_d     = SHIFTING;
    end else if (update) begin
      if (upd_act) begin
        state_d = UPDATE;
        if (!frame_ok)     frame_err_d = 1'b1;
        else if (!addr_ok) addr_err_d  = 1'b1;
        else if (frm_rd)   rd_ptr_d    = frm_addr;
      end
    end else if (shift) begin
      sr_d = {iTDI, sr_q[FRAME_LEN-1:1]};
      if (cnt_q != CNT_W'(FRAME_LEN + 1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge TCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      in_q        <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      addr_err_q  <= addr_err_d;
      frame_err_q <= frame_err_d;
      in_q        <= in_d;
    end
  end

  assign oTDO = sr_q[0];

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_chan
    jtag_user_reg_chan #(.WIDTH(WIDTH), .INIT_VAL(INIT_VAL)) u_chan (
      .TCK    (TCK),
      .RESET  (RESET),
      .we     (we[n]),
      .wdata  (frm_data),
      .q      (reg_out[n*WIDTH +: WIDTH]),
      .strobe (wr_strobe[n])
    );
  end
endmodule
